// File: rtl/brch_indx_alloc_if.sv
// Fetch-group / resolution bus between the fetch stage, the branch unit and
// the branch-index allocator.
interface brch_indx_alloc_if #(
  parameter int MAX_BRCH = 2
) ();
  localparam int CW = $clog2(MAX_BRCH + 1);

  logic          grp_vld;
  logic [3:0]    pr_need_inst;
  logic [3:0]    brch_vec;
  logic          mis_pred;
  logic [5:0]    brch_mis_indx;
  logic          cmt_brch;
  logic [5:0]    cmt_brch_indx;
  logic [6:0]    nxt_indx;
  logic          brch_stall;
  logic [CW-1:0] brch_cnt;
  logic          alloc_err;

  modport master (
    output grp_vld, pr_need_inst, brch_vec, mis_pred, brch_mis_indx,
           cmt_brch, cmt_brch_indx,
    input  nxt_indx, brch_stall, brch_cnt, alloc_err
  );

  modport slave (
    input  grp_vld, pr_need_inst, brch_vec, mis_pred, brch_mis_indx,
           cmt_brch, cmt_brch_indx,
    output nxt_indx, brch_stall, brch_cnt, alloc_err
  );
endinterface

// File: rtl/brch_indx_alloc.sv
// Branch-index allocator: ordered FIFO of unresolved branch tags, commit pop,
// mispredict truncate, capacity stall. BRCH_ALLOC_ERR_CHK_EN builds sticky alloc_err.

module brch_indx_alloc_cmp (
  input  logic [6:0] tag,
  input  logic [5:0] idx,
  input  logic       vld,
  output logic       hit
);
  assign hit = vld && (tag[5:0] == idx);
endmodule

module brch_indx_alloc #(
  parameter int MAX_BRCH = 2
) (
  input  logic             clk,
  input  logic             rst,
  brch_indx_alloc_if.slave bus
);
  localparam int CW = $clog2(MAX_BRCH + 1);
  localparam int SW = CW + 3;

  logic [MAX_BRCH-1:0][6:0] fifo_q, fifo_d, fifo_pp;
  logic [CW-1:0]            cnt_q, cnt_d, cnt_c;
  logic [6:0]               nxt_q, nxt_d;
  logic [2:0]               nb, ni;
  logic [3:0]               br;
  logic [SW-1:0]            rank;
  logic                     head_hit, pop, stall, accept;
  logic [MAX_BRCH-1:0]      ent_vld, ent_hit;
  logic                     mis_hit;
  logic [CW-1:0]            mis_pos;
  logic [6:0]               mis_tag;

  // Commit pop happens first; capacity and the mispredict search see the result.
  always_comb begin
    br       = bus.brch_vec & bus.pr_need_inst;
    nb       = '0;
    ni       = '0;
    for (int k = 0; k < 4; k++) begin
      nb = nb + {2'b0, br[k]};
      ni = ni + {2'b0, bus.pr_need_inst[k]};
    end
    head_hit = (cnt_q != '0) && (fifo_q[0][5:0] == bus.cmt_brch_indx);
    pop      = bus.cmt_brch && head_hit;
    cnt_c    = cnt_q - CW'(pop);
    stall    = bus.grp_vld && (({3'b0, cnt_c} + SW'(nb)) > SW'(MAX_BRCH));
    for (int i = 0; i < MAX_BRCH - 1; i++)
      fifo_pp[i] = pop ? fifo_q[i+1] : fifo_q[i];
    fifo_pp[MAX_BRCH-1] = pop ? 7'd0 : fifo_q[MAX_BRCH-1];
  end

  genvar g;
  generate
    for (g = 0; g < MAX_BRCH; g++) begin : g_ent
      assign ent_vld[g] = CW'(g) < cnt_c;
      brch_indx_alloc_cmp u_cmp (
        .tag (fifo_pp[g]),
        .idx (bus.brch_mis_indx),
        .vld (ent_vld[g]),
        .hit (ent_hit[g])
      );
    end
  endgenerate

  // Oldest matching entry wins.
  always_comb begin
    mis_hit = 1'b0;
    mis_pos = '0;
    mis_tag = '0;
    for (int i = 0; i < MAX_BRCH; i++) begin
      if (!mis_hit && ent_hit[i]) begin
        mis_hit = 1'b1;
        mis_pos = CW'(i);
        mis_tag = fifo_pp[i];
      end
    end
  end

  always_comb begin
    accept = bus.grp_vld && !stall && !bus.mis_pred;
    fifo_d = fifo_pp;
    cnt_d  = cnt_c;
    nxt_d  = nxt_q;
    rank   = {3'b0, cnt_c};
    if (bus.mis_pred && mis_hit) begin
      cnt_d = mis_pos;
      nxt_d = mis_tag + 7'd1;
    end
    if (accept) begin
      // Branch slot k lands at position cnt_c + (branches before k).
      for (int k = 0; k < 4; k++) begin
        if (br[k]) begin
          for (int i = 0; i < MAX_BRCH; i++)
            if (rank == SW'(i)) fifo_d[i] = nxt_q + 7'(k);
          rank = rank + SW'(1);
        end
      end
      cnt_d = cnt_c + CW'(nb);
      nxt_d = nxt_q + {4'b0, ni};
    end
    for (int i = 0; i < MAX_BRCH; i++)
      if (CW'(i) >= cnt_d) fifo_d[i] = 7'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q <= '0;
      cnt_q  <= '0;
      nxt_q  <= '0;
    end else begin
      fifo_q <= fifo_d;
      cnt_q  <= cnt_d;
      nxt_q  <= nxt_d;
    end
  end

  assign bus.nxt_indx   = nxt_q;
  assign bus.brch_cnt   = cnt_q;
  assign bus.brch_stall = stall;

`ifdef BRCH_ALLOC_ERR_CHK_EN
  logic err_q, err_d;

  always_comb
    err_d = err_q | (bus.cmt_brch && !head_hit) | (bus.mis_pred && !mis_hit);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.alloc_err = err_q;
`else
  assign bus.alloc_err = 1'b0;
`endif

endmodule

// File: tb/tb_brch_indx_alloc.sv
// Directed-vector bench for brch_indx_alloc; expectations queued per cycle and
// checked by an independent negedge monitor.
module tb_brch_indx_alloc;
  localparam int MAX_BRCH = 2;
`ifdef BRCH_ALLOC_ERR_CHK_EN
  localparam int E = 1;
`else
  localparam int E = 0;
`endif

  typedef struct {
    string    nm;
    int       due;
    bit       chk_state;
    int       stall;
    int       nxt;
    int       cnt;
    int       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  brch_indx_alloc_if #(.MAX_BRCH(MAX_BRCH)) bus ();

  brch_indx_alloc #(.MAX_BRCH(MAX_BRCH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input string fld, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s %s got %0d expected %0d", nm, fld, got, exp);
    end
  endtask

  // Monitor: compares whatever expectation is due this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.due != cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s late check due %0d now %0d", e.nm, e.due, cyc);
        end else begin
          chk(e.nm, "brch_stall", int'(bus.brch_stall), e.stall);
          if (e.chk_state) begin
            chk(e.nm, "nxt_indx", int'(bus.nxt_indx), e.nxt);
            chk(e.nm, "brch_cnt", int'(bus.brch_cnt), e.cnt);
            chk(e.nm, "alloc_err", int'(bus.alloc_err), e.err);
          end
        end
      end
    end
  end

  // One cycle of stimulus; expected outputs are those visible during this cycle.
  task automatic vec(input string nm, input bit r, input bit grp, input logic [3:0] need,
                     input logic [3:0] bv, input bit mp, input int mpi, input bit cm,
                     input int cmi, input bit chk_st, input int e_stall, input int e_nxt,
                     input int e_cnt, input int e_err);
    exp_t e;
    rst               = r;
    bus.grp_vld       = grp;
    bus.pr_need_inst  = need;
    bus.brch_vec      = bv;
    bus.mis_pred      = mp;
    bus.brch_mis_indx = 6'(mpi);
    bus.cmt_brch      = cm;
    bus.cmt_brch_indx = 6'(cmi);
    e.nm = nm; e.due = cyc; e.chk_state = chk_st;
    e.stall = e_stall; e.nxt = e_nxt; e.cnt = e_cnt; e.err = e_err;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.grp_vld = 0; bus.pr_need_inst = 0; bus.brch_vec = 0;
    bus.mis_pred = 0; bus.brch_mis_indx = 0; bus.cmt_brch = 0; bus.cmt_brch_indx = 0;
    @(posedge clk);
    #1;
    //   name         rst grp need     bv       mp mpi cm cmi chk stl nxt cnt err
    vec("rst0",        1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0,  0,  0, 0);
    vec("rst_grp",     1, 1, 4'b1111, 4'b0000, 0, 0, 0, 0, 1, 0,  0,  0, 0);
    vec("rst_state",   0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0,  0,  0, 0);
    vec("grp_nobr",    0, 1, 4'b1111, 4'b0000, 0, 0, 0, 0, 1, 0,  0,  0, 0);
    vec("grp_2br",     0, 1, 4'b1111, 4'b0101, 0, 0, 0, 0, 1, 0,  4,  0, 0);
    vec("stall_a",     0, 1, 4'b1111, 4'b0001, 0, 0, 0, 0, 1, 1,  8,  2, 0);
    vec("stall_hold",  0, 1, 4'b1111, 4'b0001, 0, 0, 0, 0, 1, 1,  8,  2, 0);
    vec("cmt_frees",   0, 1, 4'b1111, 4'b0001, 0, 0, 1, 4, 1, 0,  8,  2, 0);
    vec("after_cmt",   0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0, 12,  2, 0);
    vec("mis_tail",    0, 1, 4'b1111, 4'b0000, 1, 8, 0, 0, 1, 0, 12,  2, 0);
    vec("mis_head",    0, 1, 4'b1111, 4'b1111, 1, 6, 0, 0, 1, 1,  9,  1, 0);
    vec("after_mis",   0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0,  7,  0, 0);
    vec("mis_empty",   0, 0, 4'b0000, 4'b0000, 1, 5, 0, 0, 1, 0,  7,  0, 0);
    vec("mis_err",     0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0,  7,  0, E);
    vec("cmt_empty",   0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0, 1, 0,  7,  0, E);
    vec("cmt_e_err",   0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0,  7,  0, E);
    vec("rst_mid",     1, 1, 4'b1111, 4'b0001, 0, 0, 1, 0, 1, 0,  7,  0, E);
    for (int i = 0; i < 31; i++)
      vec("walk",      0, 1, 4'b1111, 4'b0000, 0, 0, 0, 0, 1, 0, 4*i, 0, 0);
    vec("walk_2",      0, 1, 4'b0011, 4'b0000, 0, 0, 0, 0, 1, 0, 124, 0, 0);
    vec("wrap_push",   0, 1, 4'b1111, 4'b1000, 0, 0, 0, 0, 1, 0, 126, 0, 0);
    vec("cmt_wrap",    0, 0, 4'b0000, 4'b0000, 0, 0, 1, 1, 1, 0,  2,  1, 0);
    vec("after_wrap",  0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0,  2,  0, 0);
    vec("push_4",      0, 1, 4'b0111, 4'b0100, 0, 0, 0, 0, 1, 0,  2,  0, 0);
    vec("cmt_nomatch", 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 9, 1, 0,  5,  1, 0);
    vec("cmt_nm_res",  0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0,  5,  1, E);
    vec("cmt_4",       0, 0, 4'b0000, 4'b0000, 0, 0, 1, 4, 1, 0,  5,  1, E);
    vec("err_sticky",  0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0,  5,  0, E);
    vec("mask_bv",     0, 1, 4'b0011, 4'b1100, 0, 0, 0, 0, 1, 0,  5,  0, E);
    vec("fill_2",      0, 1, 4'b1111, 4'b0011, 0, 0, 0, 0, 1, 0,  7,  0, E);
    vec("full_nb0",    0, 1, 4'b1111, 4'b0000, 0, 0, 0, 0, 1, 0, 11,  2, E);
    vec("full_stall",  0, 1, 4'b0001, 4'b0001, 0, 0, 0, 0, 1, 1, 15,  2, E);
    vec("mis_p0",      0, 1, 4'b0001, 4'b0001, 1, 7, 0, 0, 1, 1, 15,  2, E);
    vec("after_p0",    0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0,  8,  0, E);
    vec("rst_end",     1, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0,  8,  0, E);
    vec("rst_clear",   0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 0,  0,  0, 0);

    for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain %0d checks left pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
